// File: rtl/accel_pkg.sv
// Shared definitions for the INT8 dot-product accelerator: register map,
// widths, controller states and the 4-lane dot-product helper.
package accel_pkg;

    localparam int ADDR_W  = 10;
    localparam int BANK_AW = 9;
    localparam int DEPTH   = 512;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 10;
    localparam int LANE_W  = 8;
    localparam int LANES   = 4;
    localparam int SUM_W   = 18;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed 4-lane INT8 dot product; each product fits 16 bits, the sum fits 18.
    function automatic logic signed [SUM_W-1:0] dot4(input logic [DATA_W-1:0] w,
                                                     input logic [DATA_W-1:0] a);
        logic signed [SUM_W-1:0]    sum;
        logic signed [LANE_W-1:0]   wl;
        logic signed [LANE_W-1:0]   al;
        logic signed [2*LANE_W-1:0] prod;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            wl   = w[i*LANE_W +: LANE_W];
            al   = a[i*LANE_W +: LANE_W];
            prod = wl * al;
            sum  = sum + SUM_W'(prod);
        end
        return sum;
    endfunction

endpackage

// File: rtl/accel_sram.sv
// Single-port-write / single-port-read scratchpad with one cycle of read
// latency. Contents are deliberately not reset.
module accel_sram
    import accel_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int AW      = BANK_AW,
    parameter int DW      = DATA_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] ram_block [DEPTH_P];
    logic [DW-1:0] rdata_q;

    // Memory write and registered synchronous read
    always_ff @(posedge clk) begin
        if (we_i) begin
            ram_block[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= ram_block[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/accel_soc.sv
// INT8 dot-product accelerator top: AXI-lite register slave, controller FSM,
// 4-lane PE datapath and two scratchpads with a host backdoor write port.
// Build option: define CLK_GATE_EN to clock the accumulator from a
// latch-based gate that is only open while the accelerator works.
module accel_soc
    import accel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [3:0]        s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              host_mem_we,
    input  logic [ADDR_W-1:0] host_mem_addr,
    input  logic [DATA_W-1:0] host_mem_wdata
);

    logic              awready_q;
    logic              wready_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  runLen_q;
    logic [LEN_W-1:0]  cnt_q;
    state_t            state_q;
    logic              done_q;
    logic              rdValid_q;
    logic [31:0]       result_q;

    logic              isIdle;
    logic              wrFire;
    logic              startReq;
    logic              accClear;
    logic              accAdd;
    logic              rdEn;
    logic              w_we_mux;
    logic              a_we_mux;
    logic              peClk;
    logic [DATA_W-1:0] wRdata;
    logic [DATA_W-1:0] aRdata;
    logic [31:0]       readMux_d;
    logic signed [SUM_W-1:0] laneSum;
    logic              unusedBits;

    assign isIdle   = (state_q == ST_IDLE);
    assign wrFire   = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign startReq = wrFire && (s_axi_awaddr[3:2] == REG_CTRL) && s_axi_wdata[0];
    assign accClear = startReq & isIdle;
    assign accAdd   = rdValid_q;
    assign rdEn     = (state_q == ST_RUN) && (cnt_q < runLen_q);
    assign w_we_mux = host_mem_we & isIdle & ~host_mem_addr[ADDR_W-1];
    assign a_we_mux = host_mem_we & isIdle &  host_mem_addr[ADDR_W-1];
    assign laneSum  = dot4(wRdata, aRdata);
    assign unusedBits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:LEN_W]};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;

    accel_sram u_sram_weight (
        .clk     (clk),
        .we_i    (w_we_mux),
        .waddr_i (host_mem_addr[BANK_AW-1:0]),
        .wdata_i (host_mem_wdata),
        .re_i    (rdEn),
        .raddr_i (cnt_q[BANK_AW-1:0]),
        .rdata_o (wRdata)
    );

    accel_sram u_sram_act (
        .clk     (clk),
        .we_i    (a_we_mux),
        .waddr_i (host_mem_addr[BANK_AW-1:0]),
        .wdata_i (host_mem_wdata),
        .re_i    (rdEn),
        .raddr_i (cnt_q[BANK_AW-1:0]),
        .rdata_o (aRdata)
    );

    // Register read mux, sampled when the read address handshake completes
    always_comb begin
        readMux_d = 32'd0;
        case (s_axi_araddr[3:2])
            REG_CTRL:   readMux_d = 32'd0;
            REG_LEN:    readMux_d = {{(32-LEN_W){1'b0}}, len_q};
            REG_STATUS: readMux_d = {30'd0, done_q, isIdle};
            REG_RESULT: readMux_d = result_q;
            default:    readMux_d = 32'd0;
        endcase
    end

    // Write channel: one-cycle ready pulse once address and data are both present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            len_q     <= '0;
        end else begin
            awready_q <= !awready_q && s_axi_awvalid && s_axi_wvalid;
            wready_q  <= !awready_q && s_axi_awvalid && s_axi_wvalid;
            if (wrFire && (s_axi_awaddr[3:2] == REG_LEN)) begin
                len_q <= s_axi_wdata[LEN_W-1:0];
            end
        end
    end

    // Read channel: accept one address, then hold the response until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
            if (arready_q && s_axi_arvalid) begin
                rvalid_q <= 1'b1;
                rdata_q  <= readMux_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Controller: streams LEN addresses to both banks, drains the read pipe, flags done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            runLen_q  <= '0;
            done_q    <= 1'b0;
            rdValid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdValid_q <= 1'b0;
                    if (startReq) begin
                        if (len_q != '0) begin
                            state_q  <= ST_RUN;
                            cnt_q    <= '0;
                            runLen_q <= len_q;
                            done_q   <= 1'b0;
                        end else begin
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    rdValid_q <= rdEn;
                    if (rdEn) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (!rdEn && rdValid_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rdValid_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rdValid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_GATE_EN
    logic gateEn;
    logic gateLatch;

    // The gate also opens on the START edge so the RESULT clear still lands
    assign gateEn = (state_q == ST_RUN) || (state_q == ST_DONE) || accClear;

    // Glitch-free gate: enable is captured only while the clock is low
    always_latch begin
        if (!clk) begin
            gateLatch <= gateEn;
        end
    end

    assign peClk = clk & gateLatch;
`else
    assign peClk = clk;
`endif

    // Accumulator: sign-extended lane sum added each valid cycle, wraps mod 2^32
    always_ff @(posedge peClk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
        end else if (accClear) begin
            result_q <= 32'd0;
        end else if (accAdd) begin
            result_q <= result_q + {{(32-SUM_W){laneSum[SUM_W-1]}}, laneSum};
        end
    end

endmodule

// File: tb/tb_accel_soc.sv
// Self-checking bench for accel_soc: directed scenarios plus randomized
// dot-product jobs checked against a plain-arithmetic reference model.
module tb_accel_soc;

    logic        clk;
    logic        rst;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        host_mem_we;
    logic [9:0]  host_mem_addr;
    logic [31:0] host_mem_wdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wModel [512];
    logic [31:0] aModel [512];

    accel_soc dut (
        .clk            (clk),
        .rst            (rst),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .host_mem_we    (host_mem_we),
        .host_mem_addr  (host_mem_addr),
        .host_mem_wdata (host_mem_wdata)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence wedges somewhere unbounded
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference dot product over words 0..len-1, straight from the lane rules
    function automatic logic [31:0] modelDot(input int len);
        int acc;
        logic [31:0] wWord;
        logic [31:0] aWord;
        logic signed [7:0] wb;
        logic signed [7:0] ab;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            wWord = wModel[i];
            aWord = aModel[i];
            for (int l = 0; l < 4; l++) begin
                wb  = wWord[8*l +: 8];
                ab  = aWord[8*l +: 8];
                acc = acc + int'(wb) * int'(ab);
            end
        end
        return 32'(acc);
    endfunction

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_axi_awready) break;
        end
        checkOutput("aw_w_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checkOutput("awready_pulse", {31'd0, s_axi_awready}, 32'd0);
    endtask

    task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_axi_arready) break;
        end
        tick();
        s_axi_arvalid = 1'b0;
        checkOutput("rvalid_after_ar", {31'd0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    task automatic backdoorWrite(input logic [9:0] addr, input logic [31:0] data,
                                 input int holdCycles, input bit updateModel);
        host_mem_addr  = addr;
        host_mem_wdata = data;
        host_mem_we    = 1'b1;
        repeat (holdCycles) tick();
        host_mem_we    = 1'b0;
        if (updateModel) begin
            if (addr[9]) aModel[addr[8:0]] = data;
            else         wModel[addr[8:0]] = data;
        end
    endtask

    task automatic waitIdle(output logic [31:0] status);
        status = 32'd0;
        for (int i = 0; i < 400; i++) begin
            axiRead(4'h8, status);
            if (status[0]) break;
        end
    endtask

    task automatic runJob(input int len, output logic [31:0] status,
                          output logic [31:0] result);
        axiWrite(4'h4, 32'(len));
        axiWrite(4'h0, 32'd1);
        waitIdle(status);
        axiRead(4'hC, result);
    endtask

    // Randomized job: fresh random operands, run, compare against the model
    task automatic applyStimulus(input int len, input string tag);
        logic [31:0] status;
        logic [31:0] result;
        for (int i = 0; i < len; i++) begin
            backdoorWrite(10'(i), $urandom, 1, 1'b1);
            backdoorWrite(10'(i) | 10'h200, $urandom, 1, 1'b1);
        end
        runJob(len, status, result);
        checkOutput({tag, "_status"}, status, 32'd3);
        checkOutput({tag, "_result"}, result, modelDot(len));
    endtask

    initial begin
        logic [31:0] status;
        logic [31:0] result;
        logic [31:0] rd;

        rst            = 1'b0;
        s_axi_awaddr   = '0;
        s_axi_awvalid  = 1'b0;
        s_axi_wdata    = '0;
        s_axi_wvalid   = 1'b0;
        s_axi_araddr   = '0;
        s_axi_arvalid  = 1'b0;
        s_axi_rready   = 1'b0;
        host_mem_we    = 1'b0;
        host_mem_addr  = '0;
        host_mem_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            wModel[i] = '0;
            aModel[i] = '0;
        end

        // Reset state
        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        checkOutput("rst_wready",  {31'd0, s_axi_wready},  32'd0);
        checkOutput("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        checkOutput("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        checkOutput("rst_rdata",   s_axi_rdata,            32'd0);
        axiRead(4'h8, rd);
        checkOutput("rst_status", rd, 32'd1);
        axiRead(4'hC, rd);
        checkOutput("rst_result", rd, 32'd0);
        axiRead(4'h4, rd);
        checkOutput("rst_len", rd, 32'd0);

        // Backdoor write held two cycles, then a simple positive job
        backdoorWrite(10'h000, 32'h02020202, 2, 1'b1);
        checkOutput("bd_weight0", dut.u_sram_weight.ram_block[0], 32'h02020202);
        backdoorWrite(10'h200, 32'h03030303, 1, 1'b1);
        checkOutput("bd_act0", dut.u_sram_act.ram_block[0], 32'h03030303);
        runJob(1, status, result);
        checkOutput("pos_status", status, 32'd3);
        checkOutput("pos_result", result, 32'h00000018);

        // Negative lanes
        backdoorWrite(10'h000, 32'hFFFFFFFF, 1, 1'b1);
        backdoorWrite(10'h200, 32'h01010101, 1, 1'b1);
        runJob(1, status, result);
        checkOutput("neg_status", status, 32'd3);
        checkOutput("neg_result", result, 32'hFFFFFFFC);

        // Four-word job with a backdoor write attempted while busy
        for (int i = 0; i < 4; i++) begin
            backdoorWrite(10'(i), 32'h01010101, 1, 1'b1);
            backdoorWrite(10'(i) | 10'h200, 32'h7F7F7F7F, 1, 1'b1);
        end
        axiWrite(4'h4, 32'd4);
        axiWrite(4'h0, 32'd1);
        backdoorWrite(10'h001, 32'h7F7F7F7F, 1, 1'b0);
        waitIdle(status);
        axiRead(4'hC, result);
        checkOutput("len4_status", status, 32'd3);
        checkOutput("len4_result", result, 32'h000007F0);
        checkOutput("busy_bd_dropped", dut.u_sram_weight.ram_block[1], 32'h01010101);

        // Read response stalled by rready low; no new arready meanwhile
        axiWrite(4'h4, 32'h0AB);
        s_axi_araddr  = 4'h4;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_axi_arready) break;
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rvalid",  {31'd0, s_axi_rvalid},  32'd1);
            checkOutput("stall_rdata",   s_axi_rdata,            32'h0AB);
            checkOutput("stall_arready", {31'd0, s_axi_arready}, 32'd0);
            tick();
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        tick();
        s_axi_rready  = 1'b0;
        checkOutput("stall_release", {31'd0, s_axi_rvalid}, 32'd0);

        // Address without data must wait for data
        s_axi_awaddr  = 4'h4;
        s_axi_wdata   = 32'h155;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("aw_only_no_ready", {31'd0, s_axi_awready}, 32'd0);
        end
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_axi_awready) break;
        end
        checkOutput("aw_late_w_ready", {31'd0, s_axi_awready}, 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        axiRead(4'h4, rd);
        checkOutput("aw_late_w_len", rd, 32'h155);

        // START with LEN=0 clears RESULT and sets done immediately
        axiWrite(4'h4, 32'd0);
        axiWrite(4'h0, 32'd1);
        axiRead(4'h8, rd);
        checkOutput("len0_status", rd, 32'd3);
        axiRead(4'hC, rd);
        checkOutput("len0_result", rd, 32'd0);
        axiRead(4'h0, rd);
        checkOutput("ctrl_reads_zero", rd, 32'd0);

        // Reset in the middle of a long run, then rerun the same job
        for (int i = 0; i < 100; i++) begin
            backdoorWrite(10'(i), $urandom, 1, 1'b1);
            backdoorWrite(10'(i) | 10'h200, $urandom, 1, 1'b1);
        end
        axiWrite(4'h4, 32'd100);
        axiWrite(4'h0, 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        axiRead(4'h8, rd);
        checkOutput("abort_status", rd, 32'd1);
        axiRead(4'hC, rd);
        checkOutput("abort_result", rd, 32'd0);
        runJob(100, status, result);
        checkOutput("rerun_status", status, 32'd3);
        checkOutput("rerun_result", result, modelDot(100));

        // Randomized jobs, ending with a full-depth run
        for (int t = 0; t < 3; t++) begin
            applyStimulus(int'($urandom_range(1, 64)), "rand");
        end
        applyStimulus(512, "full_depth");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
